// File: rtl/counter_pkg.sv
// Shared definitions for the up-counter and countdown timer blocks.
package counter_pkg;

  // Timer control states; the encoding is visible on the state_dbg port.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    EXPIRE = 2'b10
  } timer_state_e;

  // Default widths shared with the up-counter.
  localparam int DEF_WIDTH = 5;
  localparam int DEF_CW    = 4;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with expiry pulse, optional auto-reload
// and a wrapping expiry tally.
//
// Load handshake: a load transfers on a rising clk edge where load_valid
// and load_ready are both high. load_ready is high only in IDLE. The
// timer does not back-pressure a transfer once it is offered. load_val
// only needs to be stable while load_valid is high.
//
// All outputs come from flops. There is no combinational path from any
// input to any output.
module countdown_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = DEF_CW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             enab,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt_out,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    exp_count,
  output logic [1:0]       state_dbg
);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [CW-1:0]    tally_q, tally_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  // Next-state, count, reload and tally computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tally_d  = tally_q;
    unique case (state_q)
      IDLE: begin
        // abort is deliberately ignored here.
        if (load_valid) begin
          cnt_d    = load_val;
          reload_d = load_val;
          tally_d  = '0;
          state_d  = (load_val == '0) ? EXPIRE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (enab) begin
          // A count of 0 cannot reach RUN. The <= guard keeps the register
          // from wrapping even if that assumption is ever broken.
          if (cnt_q <= WIDTH'(1)) begin
            cnt_d   = '0;
            state_d = EXPIRE;
          end else begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
      end
      EXPIRE: begin
        // done pulses in this cycle whatever abort does. Only the reload
        // is cancelled by abort.
        tally_d = tally_q + CW'(1);
        cnt_d   = '0;
        if (abort) begin
          state_d = IDLE;
        end else if (auto_reload && (reload_q != '0)) begin
          cnt_d   = reload_q;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they register together with it.
  always_comb begin
    done_d  = (state_d == EXPIRE);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      tally_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tally_q  <= tally_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign load_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cnt_out    = cnt_q;
  assign exp_count  = tally_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (WIDTH=5, CW=4).
module tb_countdown_timer;

  localparam int WIDTH = 5;
  localparam int CW    = 4;
  localparam int W     = 3 + CW + WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [WIDTH-1:0] load_val = '0;
  logic             auto_reload = 1'b0;
  logic             enab = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] cnt_out;
  logic             busy;
  logic             done;
  logic [CW-1:0]    exp_count;
  logic [1:0]       state_dbg;

  countdown_timer #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_val    (load_val),
    .auto_reload (auto_reload),
    .enab        (enab),
    .abort       (abort),
    .cnt_out     (cnt_out),
    .busy        (busy),
    .done        (done),
    .exp_count   (exp_count),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state: 0 idle, 1 run, 2 expire.
  int m_state = 0;
  int m_cnt = 0;
  int m_reload = 0;
  int m_tally = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [W-1:0] model_out();
    logic [W-1:0] v;
    v = {(m_state == 0) ? 1'b1 : 1'b0,
         (m_state != 0) ? 1'b1 : 1'b0,
         (m_state == 2) ? 1'b1 : 1'b0,
         CW'(m_tally), WIDTH'(m_cnt)};
    return v;
  endfunction

  // Advance the reference model by one clock edge using the current inputs.
  task automatic model_edge();
    if (m_state == 0) begin
      if (load_valid) begin
        m_cnt    = int'(load_val);
        m_reload = int'(load_val);
        m_tally  = 0;
        m_state  = (load_val == 0) ? 2 : 1;
      end
    end else if (m_state == 1) begin
      if (abort) begin
        m_state = 0;
        m_cnt   = 0;
      end else if (enab) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_state = 2;
      end
    end else begin
      m_tally = (m_tally + 1) % (1 << CW);
      m_cnt   = 0;
      if (abort) m_state = 0;
      else if (auto_reload && m_reload != 0) begin
        m_cnt   = m_reload;
        m_state = 1;
      end else m_state = 0;
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_reload = 0; m_tally = 0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  // Drive inputs for one cycle, predict, then compare on the next negedge.
  task automatic cyc(input logic lv, input logic [WIDTH-1:0] v, input logic ar,
                     input logic en, input logic ab);
    logic [W-1:0] got;
    load_valid = lv; load_val = v; auto_reload = ar; enab = en; abort = ab;
    model_edge();
    exp_q.push_back(model_out());
    @(negedge clk);
    got = {load_ready, busy, done, exp_count, cnt_out};
    if (exp_q.size() == 0) check("sb_empty", 32'(got), 32'hFFFF_FFFF);
    else check("sb_outputs", 32'(got), 32'(exp_q.pop_front()));
    check("sb_state", 32'(state_dbg), 32'(m_state));
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  int n;
  initial begin
    // Reset state
    @(negedge clk);
    check("rst_cnt", 32'(cnt_out), 32'h0);
    check("rst_ready", 32'(load_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_exp", 32'(exp_count), 32'h0);
    rst_n = 1'b1;
    idle_cyc(2);

    // 1: load 3, count to expiry
    cyc(1'b1, 5'h03, 1'b0, 1'b1, 1'b0);
    check("t1_cnt3", 32'(cnt_out), 32'h03);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("t1_cnt2", 32'(cnt_out), 32'h02);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("t1_cnt1", 32'(cnt_out), 32'h01);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("t1_done", 32'(done), 32'h1);
    check("t1_cnt0", 32'(cnt_out), 32'h00);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("t1_done_low", 32'(done), 32'h0);
    check("t1_ready", 32'(load_ready), 32'h1);
    check("t1_exp", 32'(exp_count), 32'h1);

    // 2: hold with enab low
    cyc(1'b1, 5'h02, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("t2_hold", 32'(cnt_out), 32'h02);
      check("t2_busy", 32'(busy), 32'h1);
    end
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("t2_done", 32'(done), 32'h1);
    idle_cyc(1);

    // 3: auto-reload of 2, then drop auto_reload
    cyc(1'b1, 5'h02, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("t3_exp3", 32'(exp_count), 32'h3);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("t3_idle", 32'(load_ready), 32'h1);

    // 4: zero load, then full-scale load latency
    cyc(1'b1, 5'h00, 1'b0, 1'b1, 1'b0);
    check("t4_zero_done", 32'(done), 32'h1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("t4_zero_exp", 32'(exp_count), 32'h1);
    cyc(1'b1, 5'h1F, 1'b0, 1'b1, 1'b0);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      if (done) begin n = i; break; end
    end
    check("t4_full_latency", 32'(n), 32'd31);
    idle_cyc(1);

    // 5a: abort in RUN at 7
    cyc(1'b1, 5'h09, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("t5_cnt7", 32'(cnt_out), 32'h07);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check("t5_abort_cnt", 32'(cnt_out), 32'h00);
    check("t5_abort_ready", 32'(load_ready), 32'h1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      check("t5_no_done", 32'(done), 32'h0);
    end
    // 5b: abort during EXPIRE with auto_reload
    cyc(1'b1, 5'h01, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("t5_expire_done", 32'(done), 32'h1);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("t5_after_abort_ready", 32'(load_ready), 32'h1);
    check("t5_after_abort_done", 32'(done), 32'h0);
    idle_cyc(1);

    // 6a: async reset mid-RUN at 0x0C
    cyc(1'b1, 5'h0F, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("t6_cnt0c", 32'(cnt_out), 32'h0C);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_cnt", 32'(cnt_out), 32'h00);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_ready", 32'(load_ready), 32'h1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle_cyc(1);

    // 6b: 16 auto-reload expiries wrap the tally
    cyc(1'b1, 5'h01, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
      if (i == 30) check("t6_exp_f", 32'(exp_count), 32'hF);
      if (i == 32) check("t6_exp_wrap", 32'(exp_count), 32'h0);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 12)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 15) == 0));
    end

    // ---------------- report ----------------
    if (exp_q.size() != 0) check("sb_leftover", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
